frame_capture_reader: RTL and testbench

//  Read-side controller for the frame-capture SDP RAM (16b x 2048, 1-cycle read latency, no output reg).
//  On a start request, streams frame_len samples from a circular buffer, beginning at base_addr, onto a

---
 rtl/frame_capture_reader_if.sv | 12 +
 rtl/frame_capture_reader.sv | 157 +++++++++++++++
 tb/tb_frame_capture_reader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_reader_if.sv
// Output sample stream of the frame-capture reader: valid/ready with an end-of-frame marker.
interface frame_capture_reader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/frame_capture_reader.sv
// Read-side controller for the frame-capture RAM: streams a circular-buffer frame onto a
// valid/ready stream, hiding RAM read latency behind a small credit-managed skid FIFO.
module frame_capture_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        frame_len,
    input  logic                   abort,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    frame_capture_reader_if.master m,
    output logic                   busy,
    output logic                   done,
    output logic                   start_drop
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TAG_N = RD_LAT + 1;   // registered address plus RAM latency
    localparam int CNT_W = $clog2(DEPTH + TAG_N + 1) + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [ADDR_W:0]   len_reg, issue_cnt, out_cnt, len_sat;
    logic              tag [TAG_N];
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt, inflight;
    logic              accept, issue, push, pop, valid, credit_ok;

    assign len_sat = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign accept  = start && !abort && (state == IDLE);
    assign push    = tag[TAG_N-1];
    assign valid   = (fifo_cnt != '0);
    assign pop     = valid && m.ready;

    // Count read requests whose data has not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < TAG_N; i++)
            inflight = inflight + CNT_W'(tag[i]);
    end

    // A beat leaving this cycle frees its slot, which keeps one issue per cycle in steady state.
    assign credit_ok = (fifo_cnt + inflight - CNT_W'(pop)) < CNT_W'(DEPTH);
    assign issue     = !abort && ((accept && (len_sat != '0)) ||
                                  ((state == READ) && (issue_cnt != len_reg) && credit_ok));

    // State register.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state logic; abort always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (len_sat == '0) ? DONE : READ;
            READ:    if (issue_cnt == len_reg) state_next = DRAIN;
            DRAIN:   if ((inflight == '0) && (fifo_cnt == CNT_W'(pop))) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state != IDLE) busy = 1'b1;
        if (state == DONE) done = 1'b1;
    end

    // Tag delay line: marks which cycles carry requested RAM data.
    genvar gi;
    generate
        for (gi = 0; gi < TAG_N; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // First stage captures the issue strobe.
                always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                    if (!rd_rst_n)  tag[gi] <= 1'b0;
                    else if (abort) tag[gi] <= 1'b0;
                    else            tag[gi] <= issue;
                end
            end else begin : g_body
                // Later stages shift the strobe along with the RAM pipeline.
                always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                    if (!rd_rst_n)  tag[gi] <= 1'b0;
                    else if (abort) tag[gi] <= 1'b0;
                    else            tag[gi] <= tag[gi-1];
                end
            end
        end
    endgenerate

    // Skid FIFO: push returning RAM data, pop on handshake, flush on abort.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rd_data;
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Frame bookkeeping: read address, issue/output counters and the dropped-start flag.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_addr    <= '0;
            len_reg    <= '0;
            issue_cnt  <= '0;
            out_cnt    <= '0;
            start_drop <= 1'b0;
        end else begin
            start_drop <= start && !abort && (state != IDLE);
            if (abort) begin
                issue_cnt <= '0;
                out_cnt   <= '0;
            end else begin
                if (accept) begin
                    len_reg <= len_sat;
                    out_cnt <= '0;
                end else if (pop) begin
                    out_cnt <= out_cnt + 1'b1;
                end
                if (accept)     issue_cnt <= {{ADDR_W{1'b0}}, issue};
                else if (issue) issue_cnt <= issue_cnt + 1'b1;
                // Address wraps naturally at 2^ADDR_W.
                if (issue) rd_addr <= accept ? base_addr : rd_addr + 1'b1;
            end
        end
    end

    assign m.valid = valid;
    assign m.data  = fifo_mem[rd_ptr];
    assign m.last  = valid && (out_cnt == len_reg - 1'b1);
endmodule

// File: tb/tb_frame_capture_reader.sv
// Directed bench for frame_capture_reader with a behavioural 1-cycle-latency RAM holding mem[a]=a.
module tb_frame_capture_reader;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   frame_len = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy, done, start_drop;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    int                total = 0;
    int                bad = 0;

    frame_capture_reader_if #(.DATA_W(DATA_W)) m_if ();

    frame_capture_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
        .rd_clk     (clk),
        .rd_rst_n   (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .frame_len  (frame_len),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m          (m_if),
        .busy       (busy),
        .done       (done),
        .start_drop (start_drop)
    );

    always #5 clk = ~clk;

    initial for (int a = 0; a < 2**ADDR_W; a++) mem[a] = DATA_W'(a);
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic test_reset;
        @(negedge clk);
        total++;
        if (rd_addr !== '0 || m_if.valid !== 1'b0 || m_if.last !== 1'b0 || m_if.data !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || start_drop !== 1'b0) begin
            bad++;
            $display("FAIL reset: addr=%0d valid=%b last=%b data=%0d busy=%b done=%b drop=%b, expected all 0",
                     rd_addr, m_if.valid, m_if.last, m_if.data, busy, done, start_drop);
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    // Len-8 frame with m_ready high; optionally fires a second start during beat 4.
    task automatic test_frame(input string name, input logic [ADDR_W-1:0] base, input bit drop);
        int dones;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_d;
        dones = 0;
        m_if.ready = 1'b1;
        @(negedge clk); start = 1'b1; base_addr = base; frame_len = 8;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) @(negedge clk);
            if (drop && k == 7) start = 1'b1;
            if (drop && k == 8) start = 1'b0;
            if (k <= 8) begin
                exp_a = base + ADDR_W'(k - 1);
                total++;
                if (rd_addr !== exp_a) begin
                    bad++;
                    $display("FAIL %s rd_addr k=%0d: got %0d, expected %0d", name, k, rd_addr, exp_a);
                end
            end
            if (k >= 3 && k <= 10) begin
                exp_a = base + ADDR_W'(k - 3);
                exp_d = DATA_W'(exp_a);
                total++;
                if (m_if.valid !== 1'b1 || m_if.data !== exp_d || m_if.last !== (k == 10)) begin
                    bad++;
                    $display("FAIL %s beat k=%0d: valid=%b data=%0d last=%b, expected valid=1 data=%0d last=%b",
                             name, k, m_if.valid, m_if.data, m_if.last, exp_d, (k == 10));
                end
                $display("%s beat %0d data=%0d last=%b", name, k - 3, m_if.data, m_if.last);
            end else begin
                total++;
                if (m_if.valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle k=%0d: valid=%b, expected 0", name, k, m_if.valid);
                end
            end
            if (done === 1'b1) dones++;
            if (k == 11) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL %s done k=11: got %b, expected 1", name, done);
                end
            end
            if (k <= 10) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy k=%0d: got %b, expected 1", name, k, busy);
                end
            end
            if (drop && (k == 8 || k == 9)) begin
                total++;
                if (start_drop !== (k == 8)) begin
                    bad++;
                    $display("FAIL %s start_drop k=%0d: got %b, expected %b", name, k, start_drop, (k == 8));
                end
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done count: got %0d, expected 1", name, dones);
        end
    endtask

    task automatic test_backpressure;
        int beats, dones, max_cnt;
        logic stall, hold_l;
        logic [DATA_W-1:0] hold_d;
        beats = 0; dones = 0; max_cnt = 0; stall = 1'b0; hold_l = 1'b0; hold_d = '0;
        m_if.ready = 1'b1;
        @(negedge clk); start = 1'b1; base_addr = 0; frame_len = 16;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300 && dones == 0; c++) begin
            if (stall) begin
                total++;
                if (m_if.valid !== 1'b1 || m_if.data !== hold_d || m_if.last !== hold_l) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d: valid=%b data=%0d last=%b, expected valid=1 data=%0d last=%b",
                             c, m_if.valid, m_if.data, m_if.last, hold_d, hold_l);
                end
            end
            if (done === 1'b1) dones++;
            if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
            m_if.ready = 1'($urandom_range(0, 1));
            stall  = m_if.valid && !m_if.ready;
            hold_d = m_if.data;
            hold_l = m_if.last;
            if (m_if.valid && m_if.ready) begin
                total++;
                if (m_if.data !== DATA_W'(beats) || m_if.last !== (beats == 15)) begin
                    bad++;
                    $display("FAIL bp beat %0d: data=%0d last=%b, expected data=%0d last=%b",
                             beats, m_if.data, m_if.last, beats, (beats == 15));
                end
                $display("bp beat %0d data=%0d last=%b", beats, m_if.data, m_if.last);
                beats++;
            end
            @(negedge clk);
        end
        m_if.ready = 1'b1;
        total++;
        if (beats != 16 || dones != 1) begin
            bad++;
            $display("FAIL bp totals: beats=%0d done=%0d, expected beats=16 done=1", beats, dones);
        end
        total++;
        if (max_cnt > 3) begin
            bad++;
            $display("FAIL bp fifo occupancy: max=%0d, expected at most 3", max_cnt);
        end
    endtask

    task automatic test_abort;
        m_if.ready = 1'b1;
        @(negedge clk); start = 1'b1; base_addr = 0; frame_len = 8;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 8; k++) @(negedge clk);
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== DATA_W'(5)) begin
            bad++;
            $display("FAIL abort pre-beat: valid=%b data=%0d, expected valid=1 data=5", m_if.valid, m_if.data);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        total++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || start_drop !== 1'b0) begin
            bad++;
            $display("FAIL abort after: valid=%b busy=%b done=%b drop=%b, expected all 0",
                     m_if.valid, busy, done, start_drop);
        end
        $display("abort issued at beat 5");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (m_if.valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort quiet %0d: valid=%b done=%b busy=%b, expected 0 0 0", k, m_if.valid, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        m_if.ready = 1'b1;
        @(negedge clk); start = 1'b1; base_addr = 0; frame_len = 8;
        @(negedge clk); start = 1'b0;
        for (int k = 2; k <= 6; k++) @(negedge clk);
        total++;
        if (m_if.valid !== 1'b1 || m_if.data !== DATA_W'(3)) begin
            bad++;
            $display("FAIL rst_mid pre-beat: valid=%b data=%0d, expected valid=1 data=3", m_if.valid, m_if.data);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0 || rd_addr !== '0 || m_if.data !== '0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid outputs: valid=%b busy=%b addr=%0d data=%0d done=%b, expected all 0",
                     m_if.valid, busy, rd_addr, m_if.data, done);
        end
        $display("reset asserted at beat 3");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1; base_addr = 5; frame_len = 0;
        @(negedge clk); start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || m_if.valid !== 1'b0) begin
            bad++;
            $display("FAIL empty frame k=1: done=%b busy=%b valid=%b, expected 1 1 0", done, busy, m_if.valid);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty frame k=2: done=%b busy=%b, expected 0 0", done, busy);
        end
        $display("empty frame completed");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (m_if.valid !== 1'b0) begin
                bad++;
                $display("FAIL empty frame beat %0d: valid=%b, expected 0", k, m_if.valid);
            end
        end
    endtask

    initial begin
        m_if.ready = 1'b1;
        test_reset();
        test_frame("basic", 11'd0, 1'b0);
        test_frame("wrap", 11'd2044, 1'b0);
        test_backpressure();
        test_frame("start_drop", 11'd0, 1'b1);
        test_abort();
        test_frame("restart", 11'd0, 1'b0);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
